pc_gen: RTL and testbench

- Program-counter generation stage that sits directly upstream of the instruction-fetch memory.
- Produces the registered next-fetch address `npc`. The fetch memory samples it on every rising edge and returns the instruction word plus the matching fetch PC.
- Handles sequential increment, branch/jump redirect from later stages, pipeline stall, and halt/resume control.

---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_redirect_cnt.sv | 20 ++
 rtl/pc_gen.sv | 118 +++++++++++
 tb/tb_pc_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared pc_gen state encodings and fetch address width
package pc_gen_pkg;

    // PC generator state encodings, also exported on pc_state for debug
    localparam logic [1:0] PCS_BOOT  = 2'd0;
    localparam logic [1:0] PCS_RUN   = 2'd1;
    localparam logic [1:0] PCS_STALL = 2'd2;
    localparam logic [1:0] PCS_HALT  = 2'd3;

    // Default fetch address width, matches the instruction memory address bus
    localparam int PC_W_DEF = 8;

    // Jump wins over branch when both redirect in the same cycle
    function automatic logic [31:0] pick_target(input logic jmp, input logic [31:0] jt,
                                                input logic [31:0] bt);
        return jmp ? jt : bt;
    endfunction

endpackage

// File: rtl/pc_redirect_cnt.sv
// rtl/pc_redirect_cnt.sv - saturating count of accepted redirects
module pc_redirect_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count up on each accepted redirect, stick at all-ones, clear only on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - next-fetch PC generator; PC_REDIRECT_CNT_EN enables the redirect counter
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic             jmp_valid,
    input  logic [PC_W-1:0]  jmp_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [PC_W-1:0]  npc,
    output logic             npc_valid,
    output logic             flush,
    output logic [1:0]       pc_state,
    output logic [CNT_W-1:0] redir_cnt
);

    logic            redir;
    logic [PC_W-1:0] redir_target;
    logic            accept;
    logic [1:0]      state_nxt;
    logic [PC_W-1:0] npc_nxt;
    logic            valid_nxt;
    logic [31:0]     target_wide;

    assign redir       = br_taken | jmp_valid;
    assign target_wide = pick_target(jmp_valid, 32'(jmp_target), 32'(br_target));
    assign redir_target = target_wide[PC_W-1:0];

    // Next-state / next-PC selection: redirect > halt/stall hold > increment
    always_comb begin
        state_nxt = pc_state;
        npc_nxt   = npc;
        valid_nxt = npc_valid;
        accept    = 1'b0;
        case (pc_state)
            PCS_BOOT: begin
                state_nxt = PCS_RUN;
                npc_nxt   = RESET_PC;
                valid_nxt = 1'b1;
            end
            PCS_RUN, PCS_STALL: begin
                accept = redir;
                if (redir) begin
                    npc_nxt = redir_target;
                end else if (halt_req || stall) begin
                    npc_nxt = npc;
                end else begin
                    npc_nxt = npc + PC_W'(1);
                end
                if (halt_req) begin
                    state_nxt = PCS_HALT;
                    valid_nxt = 1'b0;
                end else if (stall && !redir) begin
                    state_nxt = PCS_STALL;
                    valid_nxt = 1'b1;
                end else begin
                    state_nxt = PCS_RUN;
                    valid_nxt = 1'b1;
                end
            end
            PCS_HALT: begin
                accept = redir;
                if (redir) begin
                    npc_nxt = redir_target;
                end
                // Resume refetches the frozen or redirected address without incrementing
                if (resume) begin
                    state_nxt = PCS_RUN;
                    valid_nxt = 1'b1;
                end else begin
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = PCS_BOOT;
                npc_nxt   = RESET_PC;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // State, address, valid and flush registers; reset aborts to BOOT at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_state  <= PCS_BOOT;
            npc       <= RESET_PC;
            npc_valid <= 1'b0;
            flush     <= 1'b0;
        end else begin
            pc_state  <= state_nxt;
            npc       <= npc_nxt;
            npc_valid <= valid_nxt;
            flush     <= accept;
        end
    end

`ifdef PC_REDIRECT_CNT_EN
    pc_redirect_cnt #(
        .CNT_W (CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .cnt   (redir_cnt)
    );
`else
    assign redir_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [7:0]  br_target;
    logic        jmp_valid;
    logic [7:0]  jmp_target;
    logic        halt_req;
    logic        resume;
    logic [7:0]  npc;
    logic        npc_valid;
    logic        flush;
    logic [1:0]  pc_state;
    logic [15:0] redir_cnt;

    int passed = 0;
    int total  = 0;

`ifdef PC_REDIRECT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    pc_gen #(
        .PC_W     (8),
        .RESET_PC (8'h00),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .halt_req   (halt_req),
        .resume     (resume),
        .npc        (npc),
        .npc_valid  (npc_valid),
        .flush      (flush),
        .pc_state   (pc_state),
        .redir_cnt  (redir_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall = 0; br_taken = 0; br_target = 0; jmp_valid = 0; jmp_target = 0;
        halt_req = 0; resume = 0;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_npc, input logic e_v,
                           input logic e_fl, input logic [1:0] e_st, input int e_cnt);
        chk({tag, ".npc"}, 32'(npc), 32'(e_npc));
        chk({tag, ".valid"}, 32'(npc_valid), 32'(e_v));
        chk({tag, ".flush"}, 32'(flush), 32'(e_fl));
        chk({tag, ".state"}, 32'(pc_state), 32'(e_st));
        chk({tag, ".cnt"}, 32'(redir_cnt), CNT_ON ? 32'(e_cnt) : 32'd0);
    endtask

    initial begin
        clr();
        rst_n = 0;
        #12;
        chk_all("reset", 8'h00, 0, 0, S_BOOT, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk_all("boot", 8'h00, 0, 0, S_BOOT, 0);

        tick(); chk_all("run0", 8'h00, 1, 0, S_RUN, 0);
        tick(); chk_all("run1", 8'h01, 1, 0, S_RUN, 0);
        tick(); chk_all("run2", 8'h02, 1, 0, S_RUN, 0);
        tick(); chk_all("run3", 8'h03, 1, 0, S_RUN, 0);
        tick(); tick(); chk("run5", 32'(npc), 32'h05);

        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("stall", 8'h05, 1, 0, S_STALL, 0);
        end
        stall = 0;
        tick(); chk_all("unstall", 8'h06, 1, 0, S_RUN, 0);
        tick(); chk("run7", 32'(npc), 32'h07);

        br_taken = 1; br_target = 8'h00;
        tick(); chk_all("br", 8'h00, 1, 1, S_RUN, 1);
        clr();
        tick(); chk_all("after_br", 8'h01, 1, 0, S_RUN, 1);

        br_taken = 1; br_target = 8'h10; jmp_valid = 1; jmp_target = 8'h40;
        tick(); chk_all("jmp_wins", 8'h40, 1, 1, S_RUN, 2);
        clr();
        stall = 1; br_taken = 1; br_target = 8'h20;
        tick(); chk_all("redir_over_stall", 8'h20, 1, 1, S_RUN, 3);
        clr();
        tick(); chk_all("after_b2b", 8'h21, 1, 0, S_RUN, 3);

        jmp_valid = 1; jmp_target = 8'hFE;
        tick(); chk_all("jmp_fe", 8'hFE, 1, 1, S_RUN, 4);
        clr();
        tick(); chk_all("wrap_ff", 8'hFF, 1, 0, S_RUN, 4);
        tick(); chk_all("wrap_00", 8'h00, 1, 0, S_RUN, 4);

        jmp_valid = 1; jmp_target = 8'h08;
        tick(); chk("jmp_08", 32'(npc), 32'h08);
        clr();
        tick(); chk("run9", 32'(npc), 32'h09);
        halt_req = 1;
        tick(); chk_all("halt", 8'h09, 0, 0, S_HALT, 5);
        clr();
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("halted", 8'h09, 0, 0, S_HALT, 5);
        end
        jmp_valid = 1; jmp_target = 8'h30;
        tick(); chk_all("halt_jmp", 8'h30, 0, 1, S_HALT, 6);
        clr();
        tick(); chk_all("halt_hold", 8'h30, 0, 0, S_HALT, 6);
        resume = 1; halt_req = 1;
        tick(); chk_all("resume", 8'h30, 1, 0, S_RUN, 6);
        clr();
        tick(); chk_all("post_resume", 8'h31, 1, 0, S_RUN, 6);

        jmp_valid = 1; jmp_target = 8'h12;
        tick(); chk_all("jmp_12", 8'h12, 1, 1, S_RUN, 7);
        clr();
        #2;
        rst_n = 0;
        #1;
        chk_all("async_rst", 8'h00, 0, 0, S_BOOT, 0);
        @(negedge clk);
        rst_n = 1;
        jmp_valid = 1; jmp_target = 8'h55; stall = 1;
        tick(); chk_all("boot_ignores", 8'h00, 1, 0, S_RUN, 0);
        clr();
        tick(); chk_all("reboot_run", 8'h01, 1, 0, S_RUN, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
